// File: rtl/c_tile_bank_ctrl_if.sv
// Compute, store and drain signals of the multi-bank C-tile accumulator controller.
// The controller side is "slave"; the MAC array / output DMA side is "master".
interface c_tile_bank_ctrl_if #(
    parameter int unsigned D_WIDTH   = 64,
    parameter int unsigned ADDR_WTH  = 2,
    parameter int unsigned NUM_BANKS = 3,
    parameter int unsigned BANK_WTH  = $clog2(NUM_BANKS),
    parameter int unsigned N_MAX_WTH = 32
);
    logic [N_MAX_WTH-1:0] N_in;
    logic                 comp_ready;
    logic                 load_en;
    logic [D_WIDTH-1:0]   ld_data;
    logic                 ld_valid;
    logic                 store_en;
    logic [D_WIDTH-1:0]   st_data;
    logic                 drain_valid;
    logic [BANK_WTH-1:0]  drain_bank;
    logic                 drain_rd_en;
    logic [ADDR_WTH-1:0]  drain_rd_addr;
    logic [D_WIDTH-1:0]   drain_rd_data;
    logic                 drain_rd_valid;
    logic                 drain_done;
    logic [2:0]           err;

    modport master (
        output N_in, load_en, store_en, st_data, drain_rd_en, drain_rd_addr, drain_done,
        input  comp_ready, ld_data, ld_valid, drain_valid, drain_bank, drain_rd_data,
               drain_rd_valid, err
    );

    modport slave (
        input  N_in, load_en, store_en, st_data, drain_rd_en, drain_rd_addr, drain_done,
        output comp_ready, ld_data, ld_valid, drain_valid, drain_bank, drain_rd_data,
               drain_rd_valid, err
    );
endinterface

// File: rtl/c_tile_bank_ctrl.sv
// Rotating multi-bank C-tile accumulator controller: compute loads/stores N passes per tile,
// the drain side reads finished tiles and releases them with drain_done.
module c_tile_bank_ctrl #(
    parameter int unsigned D_WIDTH   = 64,
    parameter int unsigned ADDR_WTH  = 2,
    parameter int unsigned NUM_BANKS = 3,
    parameter int unsigned BANK_WTH  = $clog2(NUM_BANKS),
    parameter int unsigned N_MAX_WTH = 32,
    parameter int unsigned RD_DELAY  = 2
) (
    input logic               clk,
    input logic               rst,
    c_tile_bank_ctrl_if.slave bus
);
    localparam int unsigned Words = 2 ** ADDR_WTH;

    typedef enum logic [1:0] {StFree, StActive, StFull, StDrain} bank_state_e;

    bank_state_e          state_q [NUM_BANKS];
    bank_state_e          state_d [NUM_BANKS];
    logic [BANK_WTH-1:0]  ld_bank_q, ld_bank_d, st_bank_q, st_bank_d, dr_bank_q, dr_bank_d;
    logic [ADDR_WTH-1:0]  ld_addr_q, ld_addr_d, st_addr_q, st_addr_d;
    logic [N_MAX_WTH-1:0] ld_pass_q, ld_pass_d, st_pass_q, st_pass_d, last_pass;
    logic [2:0]           err_q, err_d;
    logic                 comp_ready, drain_valid, st_ok;
    logic                 ld_acc, st_acc, dr_rd_acc, dr_done_acc;

    logic [D_WIDTH-1:0]   mem [NUM_BANKS][Words];
    logic [RD_DELAY-1:0]  ld_vld_q, dr_vld_q;
    logic [D_WIDTH-1:0]   ld_dat_q [RD_DELAY];
    logic [D_WIDTH-1:0]   dr_dat_q [RD_DELAY];

    function automatic logic [BANK_WTH-1:0] next_bank(input logic [BANK_WTH-1:0] b);
        return (b == BANK_WTH'(NUM_BANKS - 1)) ? '0 : b + BANK_WTH'(1);
    endfunction

    assign last_pass   = (bus.N_in == '0) ? '0 : bus.N_in - N_MAX_WTH'(1);
    // Held low during reset so every output reads 0 while rst is asserted.
    assign comp_ready  = !rst && (state_q[ld_bank_q] == StFree || state_q[ld_bank_q] == StActive);
    assign drain_valid = (state_q[dr_bank_q] == StFull) || (state_q[dr_bank_q] == StDrain);
    assign st_ok       = (state_q[st_bank_q] == StActive);
    assign ld_acc      = bus.load_en && comp_ready;
    assign st_acc      = bus.store_en && st_ok;
    assign dr_rd_acc   = bus.drain_rd_en && drain_valid;
    assign dr_done_acc = bus.drain_done && drain_valid;

    always_comb begin
        state_d   = state_q;
        ld_bank_d = ld_bank_q;
        st_bank_d = st_bank_q;
        dr_bank_d = dr_bank_q;
        ld_addr_d = ld_addr_q;
        st_addr_d = st_addr_q;
        ld_pass_d = ld_pass_q;
        st_pass_d = st_pass_q;
        err_d     = err_q | {bus.drain_rd_en && !drain_valid, bus.store_en && !st_ok,
                             bus.load_en && !comp_ready};

        // The three bank-state updates below can only ever target different banks,
        // since each one requires a distinct current state.
        if (ld_acc) begin
            if (state_q[ld_bank_q] == StFree) state_d[ld_bank_q] = StActive;
            ld_addr_d = ld_addr_q + ADDR_WTH'(1);
            if (&ld_addr_q) begin
                if (ld_pass_q == last_pass) begin
                    ld_pass_d = '0;
                    ld_bank_d = next_bank(ld_bank_q);
                end else begin
                    ld_pass_d = ld_pass_q + N_MAX_WTH'(1);
                end
            end
        end

        if (st_acc) begin
            st_addr_d = st_addr_q + ADDR_WTH'(1);
            if (&st_addr_q) begin
                if (st_pass_q == last_pass) begin
                    st_pass_d          = '0;
                    state_d[st_bank_q] = StFull;
                    st_bank_d          = next_bank(st_bank_q);
                end else begin
                    st_pass_d = st_pass_q + N_MAX_WTH'(1);
                end
            end
        end

        if (dr_rd_acc && state_q[dr_bank_q] == StFull) state_d[dr_bank_q] = StDrain;
        if (dr_done_acc) begin
            state_d[dr_bank_q] = StFree;
            dr_bank_d          = next_bank(dr_bank_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) state_q[i] <= StFree;
            ld_bank_q <= '0;
            st_bank_q <= '0;
            dr_bank_q <= '0;
            ld_addr_q <= '0;
            st_addr_q <= '0;
            ld_pass_q <= '0;
            st_pass_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            ld_bank_q <= ld_bank_d;
            st_bank_q <= st_bank_d;
            dr_bank_q <= dr_bank_d;
            ld_addr_q <= ld_addr_d;
            st_addr_q <= st_addr_d;
            ld_pass_q <= ld_pass_d;
            st_pass_q <= st_pass_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (st_acc) mem[st_bank_q][st_addr_q] <= bus.st_data;
    end

    // Read pipelines: data is sampled at issue, so reads in flight survive drain_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_vld_q <= '0;
            dr_vld_q <= '0;
            for (int unsigned i = 0; i < RD_DELAY; i++) begin
                ld_dat_q[i] <= '0;
                dr_dat_q[i] <= '0;
            end
        end else begin
            ld_vld_q[0] <= ld_acc;
            // Pass-0 reads are zeroed at issue; the zero travels down the pipe as the flag.
            ld_dat_q[0] <= (ld_acc && ld_pass_q != '0) ? mem[ld_bank_q][ld_addr_q] : '0;
            dr_vld_q[0] <= dr_rd_acc;
            dr_dat_q[0] <= dr_rd_acc ? mem[dr_bank_q][bus.drain_rd_addr] : '0;
            for (int unsigned i = 1; i < RD_DELAY; i++) begin
                ld_vld_q[i] <= ld_vld_q[i-1];
                ld_dat_q[i] <= ld_dat_q[i-1];
                dr_vld_q[i] <= dr_vld_q[i-1];
                dr_dat_q[i] <= dr_dat_q[i-1];
            end
        end
    end

    assign bus.comp_ready     = comp_ready;
    assign bus.drain_valid    = drain_valid;
    assign bus.drain_bank     = dr_bank_q;
    assign bus.err            = err_q;
    assign bus.ld_valid       = ld_vld_q[RD_DELAY-1];
    assign bus.ld_data        = ld_vld_q[RD_DELAY-1] ? ld_dat_q[RD_DELAY-1] : '0;
    assign bus.drain_rd_valid = dr_vld_q[RD_DELAY-1];
    assign bus.drain_rd_data  = dr_vld_q[RD_DELAY-1] ? dr_dat_q[RD_DELAY-1] : '0;
endmodule
